// File: rtl/noc_route_alloc.sv
// noc_route_alloc: single-cycle route computation and output allocation for a
// 5-port mesh router (port index N=0, S=1, E=2, W=3, L=4).
//
// Each input presents a head flit. The flit's destination (x in the upper
// coordinate field, y in the lower one) is routed Y-first, then X. A request
// whose route points back at its own input port is dropped. Every other
// request goes to one output. Each output has a credit counter and a
// round-robin arbiter. A grant registers the flit into the output stage one
// cycle later.
//
// Handshake: in_valid[i] means a head flit is present on in_data slot i.
// in_remove[i] (== credit_inc[i]) is a combinational pop that is asserted in
// the same cycle the flit is granted or dropped. The source must advance its
// queue on that edge. out_valid[o] is a registered single-cycle strobe. It
// qualifies out_data/out_sel slot o, and there is no backpressure on it.
// Backpressure comes only from credits: credit_ret[o] returns one downstream
// slot.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   in_data       5 x DATA_W head flits
//   in_valid      5 head-present flags
//   in_remove     5 combinational pops (grant or dropped U-turn)
//   credit_inc    5 credit returns to upstream, identical to in_remove
//   credit_ret    5 downstream slot-freed pulses, one per output
//   out_data      5 x DATA_W registered output flits
//   out_valid     5 registered output strobes
//   out_sel       5 x 3 registered source-input index per output
//   err           5 sticky error flags (zero unless NOC_ROUTE_ERR_EN)
//   credit_cnt    5 x 4 debug view of the per-output credit counters
//   rr_ptr        5 x 3 debug view of the per-output round-robin pointers
//
// Build option: define NOC_ROUTE_ERR_EN to add the sticky error flags. The
// flags record dropped U-turns per input and saturating credit returns per
// output.
module noc_route_alloc #(
  parameter int XCOORD  = 1,
  parameter int YCOORD  = 1,
  parameter int COORD_W = 4,
  parameter int DATA_W  = 8,
  parameter int CREDITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5*DATA_W-1:0] in_data,
  input  logic [4:0]          in_valid,
  output logic [4:0]          in_remove,
  output logic [4:0]          credit_inc,
  input  logic [4:0]          credit_ret,
  output logic [5*DATA_W-1:0] out_data,
  output logic [4:0]          out_valid,
  output logic [14:0]         out_sel,
  output logic [4:0]          err,
  output logic [19:0]         credit_cnt,
  output logic [14:0]         rr_ptr
);

  localparam logic [COORD_W-1:0] X_C    = COORD_W'(XCOORD);
  localparam logic [COORD_W-1:0] Y_C    = COORD_W'(YCOORD);
  localparam logic [3:0]         CRED_C = 4'(CREDITS);

  logic [DATA_W-1:0]  flit   [5];
  logic [COORD_W-1:0] dest_x [5];
  logic [COORD_W-1:0] dest_y [5];
  logic [2:0]         route  [5];
  logic [4:0]         drop;
  logic [4:0][4:0]    req;       // req[o][i]: input i requests output o
  logic [4:0]         gnt;
  logic [2:0]         gidx   [5];
  logic [4:0]         granted;
  logic [3:0]         cnt    [5];
  logic [2:0]         ptr    [5];

  // First requester found scanning upward from p, wrapping modulo 5.
  function automatic logic [2:0] rr_pick(input logic [2:0] p, input logic [4:0] r);
    logic [2:0] pick;
    logic       found;
    int         t;
    pick  = 3'd0;
    found = 1'b0;
    for (int k = 0; k < 5; k++) begin
      t = int'(p) + k;
      if (t >= 5) t = t - 5;
      if (!found && r[t]) begin
        found = 1'b1;
        pick  = 3'(t);
      end
    end
    return pick;
  endfunction

  // Y-first dimension-order routing on unsigned coordinates.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      flit[i]   = in_data[i*DATA_W +: DATA_W];
      dest_x[i] = flit[i][2*COORD_W-1:COORD_W];
      dest_y[i] = flit[i][COORD_W-1:0];
      if (dest_y[i] > Y_C)      route[i] = 3'd1;
      else if (dest_y[i] < Y_C) route[i] = 3'd0;
      else if (dest_x[i] > X_C) route[i] = 3'd2;
      else if (dest_x[i] < X_C) route[i] = 3'd3;
      else                      route[i] = 3'd4;
    end
  end

  // Requests are gated by credit availability. A U-turn is dropped, and that
  // drop also pops the input.
  always_comb begin
    req  = '0;
    drop = '0;
    for (int i = 0; i < 5; i++) begin
      if (!rst && in_valid[i]) begin
        if (route[i] == 3'(i))          drop[i] = 1'b1;
        else if (cnt[route[i]] != 4'd0) req[route[i]][i] = 1'b1;
      end
    end
  end

  always_comb begin
    granted = '0;
    for (int o = 0; o < 5; o++) begin
      gnt[o]  = |req[o];
      gidx[o] = rr_pick(ptr[o], req[o]);
      if (gnt[o]) granted[gidx[o]] = 1'b1;
    end
  end

  assign in_remove  = granted | drop;
  assign credit_inc = granted | drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= '0;
      out_data  <= '0;
      out_sel   <= '0;
      for (int o = 0; o < 5; o++) begin
        cnt[o] <= CRED_C;
        ptr[o] <= 3'd0;
      end
    end else begin
      out_valid <= gnt;
      for (int o = 0; o < 5; o++) begin
        if (gnt[o]) begin
          out_data[o*DATA_W +: DATA_W] <= flit[gidx[o]];
          out_sel[o*3 +: 3]            <= gidx[o];
          ptr[o]                       <= (gidx[o] == 3'd4) ? 3'd0 : gidx[o] + 3'd1;
        end
        // Grant and return in the same cycle cancel. A return at full count
        // is discarded so the counter never exceeds CREDITS.
        case ({gnt[o], credit_ret[o]})
          2'b10:   cnt[o] <= cnt[o] - 4'd1;
          2'b01:   if (cnt[o] != CRED_C) cnt[o] <= cnt[o] + 4'd1;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    credit_cnt = '0;
    rr_ptr     = '0;
    for (int o = 0; o < 5; o++) begin
      credit_cnt[o*4 +: 4] = cnt[o];
      rr_ptr[o*3 +: 3]     = ptr[o];
    end
  end

`ifdef NOC_ROUTE_ERR_EN
  logic [4:0] err_q;
  // Bit i records a U-turn dropped at input i or an overflowing return at
  // output i. The bit is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (drop[i] || (credit_ret[i] && !gnt[i] && cnt[i] == CRED_C))
          err_q[i] <= 1'b1;
      end
    end
  end
  assign err = err_q;
`else
  assign err = '0;
`endif

endmodule

// File: tb/tb_noc_route_alloc.sv
// Testbench for noc_route_alloc. Instance a uses CREDITS=4 and instance b uses
// CREDITS=2. Both instances get the same inputs. A behavioural model of each
// instance is checked every cycle. Directed literal checks cover the key
// scenarios.
module tb_noc_route_alloc;

`ifdef NOC_ROUTE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [39:0] in_data;
  logic [4:0]  in_valid;
  logic [4:0]  credit_ret;

  logic [4:0]  rm [2];
  logic [4:0]  ci [2];
  logic [39:0] od [2];
  logic [4:0]  ov [2];
  logic [14:0] os [2];
  logic [4:0]  er [2];
  logic [19:0] cc [2];
  logic [14:0] rp [2];

  noc_route_alloc #(.XCOORD(1), .YCOORD(1), .COORD_W(4), .DATA_W(8), .CREDITS(4)) u_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_remove(rm[0]), .credit_inc(ci[0]), .credit_ret(credit_ret),
    .out_data(od[0]), .out_valid(ov[0]), .out_sel(os[0]), .err(er[0]),
    .credit_cnt(cc[0]), .rr_ptr(rp[0]));

  noc_route_alloc #(.XCOORD(1), .YCOORD(1), .COORD_W(4), .DATA_W(8), .CREDITS(2)) u_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_remove(rm[1]), .credit_inc(ci[1]), .credit_ret(credit_ret),
    .out_data(od[1]), .out_valid(ov[1]), .out_sel(os[1]), .err(er[1]),
    .credit_cnt(cc[1]), .rr_ptr(rp[1]));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int route_of(input logic [7:0] d);
    int x, y;
    x = int'(d[7:4]);
    y = int'(d[3:0]);
    if (y > 1) return 1;
    if (y < 1) return 0;
    if (x > 1) return 2;
    if (x < 1) return 3;
    return 4;
  endfunction

  int         m_cred [2][5];
  int         m_ptr  [2][5];
  int         m_sel  [2][5];
  bit         m_ov   [2][5];
  bit         m_err  [2][5];
  logic [7:0] m_od   [2][5];
  bit         model_live = 1'b0;

  always @(negedge clk) begin
    int          g  [5];
    bit          dr [5];
    int          ii, cr;
    logic [4:0]  e_rm, e_ov, e_er;
    logic [39:0] e_od;
    logic [14:0] e_os, e_rp;
    logic [19:0] e_cc;
    for (int k = 0; k < 2; k++) begin
      cr = (k == 0) ? 4 : 2;
      for (int i = 0; i < 5; i++) begin
        g[i]  = -1;
        dr[i] = 1'b0;
        if (!rst && in_valid[i] && route_of(in_data[i*8 +: 8]) == i) dr[i] = 1'b1;
      end
      for (int o = 0; o < 5; o++) begin
        if (!rst && m_cred[k][o] > 0) begin
          for (int j = 0; j < 5; j++) begin
            ii = (m_ptr[k][o] + j) % 5;
            if (g[o] < 0 && ii != o && in_valid[ii] && route_of(in_data[ii*8 +: 8]) == o)
              g[o] = ii;
          end
        end
      end
      e_rm = '0;
      for (int i = 0; i < 5; i++) if (dr[i]) e_rm[i] = 1'b1;
      for (int o = 0; o < 5; o++) if (g[o] >= 0) e_rm[g[o]] = 1'b1;
      if (model_live) begin
        for (int o = 0; o < 5; o++) begin
          e_ov[o]          = m_ov[k][o];
          e_er[o]          = m_err[k][o];
          e_od[o*8 +: 8]   = m_od[k][o];
          e_os[o*3 +: 3]   = 3'(m_sel[k][o]);
          e_rp[o*3 +: 3]   = 3'(m_ptr[k][o]);
          e_cc[o*4 +: 4]   = 4'(m_cred[k][o]);
        end
        chk($sformatf("model_in_remove_%0d", k),  64'(rm[k]), 64'(e_rm));
        chk($sformatf("model_credit_inc_%0d", k), 64'(ci[k]), 64'(e_rm));
        chk($sformatf("model_out_valid_%0d", k),  64'(ov[k]), 64'(e_ov));
        chk($sformatf("model_out_data_%0d", k),   64'(od[k]), 64'(e_od));
        chk($sformatf("model_out_sel_%0d", k),    64'(os[k]), 64'(e_os));
        chk($sformatf("model_err_%0d", k),        64'(er[k]), 64'(e_er));
        chk($sformatf("model_credits_%0d", k),    64'(cc[k]), 64'(e_cc));
        chk($sformatf("model_ptr_%0d", k),        64'(rp[k]), 64'(e_rp));
      end
      // advance the model to the state after the coming rising edge
      for (int o = 0; o < 5; o++) begin
        if (rst) begin
          m_cred[k][o] = cr;
          m_ptr[k][o]  = 0;
          m_sel[k][o]  = 0;
          m_ov[k][o]   = 1'b0;
          m_err[k][o]  = 1'b0;
          m_od[k][o]   = 8'h00;
        end else begin
          m_ov[k][o] = (g[o] >= 0);
          if (g[o] >= 0) begin
            m_od[k][o]  = in_data[g[o]*8 +: 8];
            m_sel[k][o] = g[o];
            m_ptr[k][o] = (g[o] + 1) % 5;
          end
          if (g[o] >= 0 && !credit_ret[o]) m_cred[k][o] = m_cred[k][o] - 1;
          else if (g[o] < 0 && credit_ret[o]) begin
            if (m_cred[k][o] < cr) m_cred[k][o] = m_cred[k][o] + 1;
            else if (ERR_EN) m_err[k][o] = 1'b1;
          end
          if (dr[o] && ERR_EN) m_err[k][o] = 1'b1;
        end
      end
    end
    if (rst) model_live = 1'b1;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int p, input logic [7:0] d);
    in_data[p*8 +: 8] = d;
    in_valid[p]       = 1'b1;
  endtask

  task automatic idle();
    in_valid   = '0;
    in_data    = '0;
    credit_ret = '0;
  endtask

  logic [7:0] dests [6] = '{8'h10, 8'h12, 8'h21, 8'h01, 8'h11, 8'h00};
  logic [4:0] tv_valid [10] = '{5'b11111, 5'b10101, 5'b01010, 5'b11000, 5'b00111,
                                5'b11111, 5'b10001, 5'b01110, 5'b11111, 5'b00000};
  logic [4:0] tv_ret [10]   = '{5'b00000, 5'b00100, 5'b11111, 5'b00011, 5'b10000,
                                5'b01010, 5'b00000, 5'b11111, 5'b00100, 5'b11111};
  int         rot_exp [6]   = '{0, 1, 4, 0, 1, 4};
  logic [4:0] b_rm_exp [5]  = '{5'b10000, 5'b10000, 5'b00000, 5'b00000, 5'b10000};
  int         b_cnt_exp [5] = '{2, 1, 0, 0, 1};

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    idle();
    step();
    step();
    @(negedge clk);
    chk("reset_out_valid", 64'(ov[0]), 64'h0);
    chk("reset_credits",   64'(cc[0]), 64'h44444);
    chk("reset_credits_b", 64'(cc[1]), 64'h22222);
    chk("reset_err",       64'(er[0]), 64'h0);
    step();
    rst = 1'b0;

    // L -> E single flit
    send(4, 8'h21);
    @(negedge clk);
    chk("l_to_e_remove", 64'(rm[0]), 64'(5'b10000));
    chk("l_to_e_cinc",   64'(ci[0]), 64'(5'b10000));
    step();
    idle();
    @(negedge clk);
    chk("l_to_e_valid",   64'(ov[0]), 64'(5'b00100));
    chk("l_to_e_sel",     64'(os[0][8:6]), 64'd4);
    chk("l_to_e_data",    64'(od[0][23:16]), 64'h21);
    chk("l_to_e_credits", 64'(cc[0][11:8]), 64'd3);

    // N, S, L contend for E while E credits are returned every cycle
    step();
    send(0, 8'h21);
    send(1, 8'h21);
    send(4, 8'h21);
    credit_ret = 5'b00100;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("rr_remove_%0d", c), 64'(rm[0]), 64'(5'b00001 << rot_exp[c]));
      if (c > 0) chk($sformatf("rr_sel_%0d", c), 64'(os[0][8:6]), 64'(rot_exp[c-1]));
      step();
    end
    idle();
    @(negedge clk);
    chk("rr_sel_last",        64'(os[0][8:6]), 64'd4);
    chk("grant_ret_unchanged", 64'(cc[0][11:8]), 64'd3);

    // Credit return at full count saturates
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    credit_ret = 5'b11111;
    step();
    idle();
    @(negedge clk);
    chk("saturate_a", 64'(cc[0]), 64'h44444);
    chk("saturate_b", 64'(cc[1]), 64'h22222);
    chk("saturate_err", 64'(er[0]), ERR_EN ? 64'h1f : 64'h0);

    // CREDITS=2 stall and recovery on instance b
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    send(4, 8'h21);
    for (int c = 0; c < 5; c++) begin
      credit_ret = (c == 3) ? 5'b00100 : 5'b00000;
      @(negedge clk);
      chk($sformatf("stall_remove_%0d", c),  64'(rm[1]), 64'(b_rm_exp[c]));
      chk($sformatf("stall_credits_%0d", c), 64'(cc[1][11:8]), 64'(b_cnt_exp[c]));
      step();
    end
    idle();

    // U-turn on E input
    send(2, 8'h21);
    @(negedge clk);
    chk("uturn_remove", 64'(rm[0]), 64'(5'b00100));
    step();
    idle();
    @(negedge clk);
    chk("uturn_no_valid", 64'(ov[0]), 64'h0);
    chk("uturn_err",      64'(er[0]), ERR_EN ? 64'(5'b00100) : 64'h0);

    // Reset while out_valid[S] is high
    step();
    send(4, 8'h12);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid_before", 64'(ov[0]), 64'(5'b00010));
    chk("midrst_no_remove",    64'(rm[0]), 64'h0);
    step();
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk("midrst_valid", 64'(ov[0]), 64'h0);
    chk("midrst_cred",  64'(cc[0]), 64'h44444);
    chk("midrst_ptr",   64'(rp[0]), 64'h0);
    chk("midrst_data",  64'(od[0]), 64'h0);

    // Mixed directed vectors, checked by the model
    for (int v = 0; v < 10; v++) begin
      step();
      for (int p = 0; p < 5; p++) in_data[p*8 +: 8] = dests[(v*2 + p) % 6];
      in_valid   = tv_valid[v];
      credit_ret = tv_ret[v];
    end
    step();
    idle();
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_route_alloc.md
NOC_ROUTE_ALLOC -- requirements
Module: noc_route_alloc

Interface
REQ-001 Parameter XCOORD, default 1, router X coordinate.
REQ-002 Parameter YCOORD, default 1, router Y coordinate.
REQ-003 Parameter COORD_W, default 4, width of each destination coordinate field.
REQ-004 Parameter DATA_W, default 8, flit width; SHALL be >= 2*COORD_W.
REQ-005 Parameter CREDITS, default 4, downstream buffer depth per output, range 1..15.
REQ-006 Ports are indexed N=0, S=1, E=2, W=3, L=4 in every 5-bit or 5-slot vector.
REQ-007 clk  in  1  the only clock; rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 in_data  in  5*DATA_W  head flit per input port; x = [2*COORD_W-1:COORD_W], y = [COORD_W-1:0].
REQ-010 in_valid  in  5  input head flit present.
REQ-011 in_remove  out  5  combinational pop of input head, same cycle as grant.
REQ-012 credit_inc  out  5  combinational credit return to upstream, equal to in_remove.
REQ-013 credit_ret  in  5  downstream freed one slot on that output.
REQ-014 out_data  out  5*DATA_W  registered flit per output port.
REQ-015 out_valid  out  5  registered; out_data valid.
REQ-016 out_sel  out  5*3  registered index of source input for each output.
REQ-017 err  out  5  sticky per-input error flags (see Configuration).

Function
REQ-018 Routing, every input identically: dest y > YCOORD -> S; y < YCOORD -> N; else x > XCOORD -> E; x < XCOORD -> W; else L (unsigned compare).
REQ-019 A request whose route equals its own input port (U-turn) SHALL be dropped: in_remove and credit_inc pulse for one cycle, and no output is driven.
REQ-020 Each output has a 4-bit credit counter; a request to that output is eligible only when the count is > 0.
REQ-021 Each output runs a round-robin arbiter over eligible inputs, starting the search at its pointer ptr[o] and scanning ascending modulo 5.
REQ-022 At most one grant per output per cycle; each input is routed to exactly one output, so it is granted at most once per cycle.
REQ-023 On grant of input i to output o in cycle t: in_remove[i]=credit_inc[i]=1 in t; at edge t+1 out_data[o]<=in_data[i], out_sel[o]<=i, out_valid[o]<=1; ptr[o]<=(i+1) mod 5.
REQ-024 Without a grant, out_valid[o]<=0, out_data[o] and out_sel[o] hold their values, and ptr[o] holds.
REQ-025 Latency: exactly 1 cycle from grant to out_valid; full throughput of one flit per output per cycle.
REQ-026 Credit update per cycle: grant only -> -1; credit_ret only -> +1; both -> unchanged; neither -> unchanged.
REQ-027 credit_ret with the count at CREDITS and no grant SHALL be ignored (saturate); the count SHALL never underflow.
REQ-028 in_valid=0 SHALL produce no request, regardless of in_data.

Reset
REQ-029 While rst=1 at an edge: credit counters<=CREDITS, ptr<=0, out_valid<=0, out_data<=0, out_sel<=0, err<=0.
REQ-030 During reset cycles in_remove and credit_inc SHALL be 0; no grants are issued.
REQ-031 Reset asserted mid-traffic discards any in-flight output register contents; the first grant is possible in the first cycle with rst=0.

Configuration
REQ-032 Macro NOC_ROUTE_ERR_EN defined: err[i] sets on a dropped U-turn from input i, or on a saturating credit_ret at output i; it clears only on rst.
REQ-033 NOC_ROUTE_ERR_EN undefined: err is tied to 0 and no error flops exist; all routing, drop and credit behaviour is unchanged.

Verification
REQ-034 XCOORD=1, YCOORD=1, reset; L sends 8'h21 -> E out_valid the next cycle, out_sel[E]=4, out_data[E]=8'h21, E credits 4->3.
REQ-035 N, S and L all target E (data 8'h21, 8'h21 with y=1 and x=2) each cycle -> E grants rotate 0, 1, 4, 0, ...; exactly one in_remove per cycle.
REQ-036 CREDITS=2, no credit_ret; L sends 3 flits to E -> 2 granted; the 3rd stalls with in_remove=0; one credit_ret pulse -> 3rd granted the cycle after the counter reaches 1.
REQ-037 E input with x=2 (U-turn to E) -> in_remove[E]=1, no out_valid; err[E]=1 only with NOC_ROUTE_ERR_EN.
REQ-038 Grant and credit_ret on the same output in the same cycle -> count unchanged; credit_ret at count 4 -> count stays 4.
REQ-039 rst asserted for 1 cycle while out_valid[S]=1 -> next cycle out_valid=0, credits=CREDITS, ptr=0.
